// File: rtl/imem_pkg.sv
// Shared types and default sizing for the instruction fetch block.
package imem_pkg;

  // Program-load phase followed by the read-only fetch phase.
  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } imem_state_t;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DEPTH     = 512;
  localparam int DEF_RSP_DEPTH = 2;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Small response buffer: in-order FIFO with flush; a push into a full
// buffer is accepted only when a pop happens in the same cycle.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W + 1,
  parameter int DEPTH = DEF_RSP_DEPTH
) (
  input  logic                         Clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointers advance modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = store[rd_ptr];

  // Occupancy and pointer bookkeeping; flush empties the buffer.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; only the pointers define validity.
  always_ff @(posedge Clock) begin
    if (!flush && do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/imem_fetch.sv
// Instruction memory with a program-load phase and a pipelined fetch port.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits for ready, and a response stays presented
// until it is consumed or flushed.
module imem_fetch
  import imem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic                             Clock,
  input  logic                             reset,
  input  logic                             load_en,
  input  logic [ADDR_W-1:0]                load_addr,
  input  logic [DATA_W-1:0]                load_data,
  input  logic                             load_done,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_W-1:0]                req_addr,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_W-1:0]                rsp_data,
  output logic                             rsp_err,
  input  logic                             flush,
  output imem_state_t                      fsm_state,
  output logic [$clog2(RSP_DEPTH+1)-1:0]   rsp_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  imem_state_t       state;
  imem_state_t       state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic              rd_err;
  logic              inflight;
  logic              accept;
  logic              load_ok;
  logic              req_oob;
  logic [CW:0]       occupancy;
  logic [DATA_W:0]   fifo_head;
  logic [DATA_W:0]   bypass_word;
  logic [DATA_W:0]   head_word;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              bypass;

  assign req_oob   = ({1'b0, req_addr} >= (ADDR_W + 1)'(DEPTH));
  assign load_ok   = load_en && ({1'b0, load_addr} < (ADDR_W + 1)'(DEPTH));
  assign occupancy = {1'b0, fifo_count} + (CW + 1)'(inflight);
  assign accept    = req_valid && req_ready;

  // FSM state register.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) state <= ST_LOAD;
    else        state <= state_next;
  end

  // Next state and request gating: fetches only in RUN, with room reserved
  // for every response not yet consumed.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    case (state)
      ST_LOAD: if (load_done) state_next = ST_RUN;
      ST_RUN:  req_ready = !flush && (occupancy < (CW + 1)'(RSP_DEPTH));
      default: state_next = ST_LOAD;
    endcase
  end

  // Program load port; writes outside the array are dropped.
  always_ff @(posedge Clock) begin
    if (state == ST_LOAD && load_ok) mem[load_addr[IW-1:0]] <= load_data;
  end

  // Synchronous array read for an accepted request.
  always_ff @(posedge Clock) begin
    if (accept) rd_word <= mem[req_addr[IW-1:0]];
  end

  // One-cycle in-flight marker plus the range flag of that read.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      inflight <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) rd_err <= req_oob;
    end
  end

  // The read result bypasses the buffer when nothing older is waiting,
  // otherwise (or if not consumed this cycle) it is queued behind.
  assign bypass_word = {rd_err, (rd_err ? {DATA_W{1'b0}} : rd_word)};
  assign bypass      = inflight && fifo_empty;
  assign head_word   = bypass ? bypass_word : fifo_head;
  assign fifo_push   = inflight && !(bypass && rsp_ready);
  assign fifo_pop    = !fifo_empty && rsp_ready;

  imem_rsp_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .Clock     (Clock),
    .reset     (reset),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (bypass_word),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign rsp_valid = bypass || !fifo_empty;
  assign rsp_data  = rsp_valid ? head_word[DATA_W-1:0] : '0;
  assign rsp_err   = rsp_valid && head_word[DATA_W];
  assign fsm_state = state;
  assign rsp_count = fifo_count;

endmodule

// File: tb/tb_imem_fetch.sv
// Randomized bench for imem_fetch against a queue-based reference model.
module tb_imem_fetch;
  import imem_pkg::*;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int DEPTH     = 512;
  localparam int RSP_DEPTH = 2;
  localparam int CW        = $clog2(RSP_DEPTH + 1);

  logic              Clock = 1'b0;
  logic              reset = 1'b0;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_done;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              flush;
  imem_state_t       fsm_state;
  logic [CW-1:0]     rsp_count;

  // Reference model: word contents, phase, and outstanding responses
  // ({err, data}) in the order they must be delivered.
  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W-1:0] mem_m [DEPTH];
  bit                run_m;
  bit                last_acc;
  int                n_tests;
  int                n_fail;
  bit                acc;

  imem_fetch #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .Clock     (Clock),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .load_done (load_done),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .flush     (flush),
    .fsm_state (fsm_state),
    .rsp_count (rsp_count)
  );

  // Clock and watchdog.
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W:0] exp_word(input logic [ADDR_W-1:0] a);
    if (int'(a) >= DEPTH) return {1'b1, {DATA_W{1'b0}}};
    return {1'b0, mem_m[a[8:0]]};
  endfunction

  // One clock: check outputs at the falling edge, then advance the model
  // with whatever transfers happen at the rising edge.
  task automatic cycle(output bit accepted);
    logic exp_ready;
    logic exp_valid;
    @(negedge Clock);
    exp_ready = run_m && !flush && (exp_q.size() < RSP_DEPTH);
    exp_valid = (exp_q.size() != 0);
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("rsp_data", 32'(rsp_data), 32'(exp_q[0][DATA_W-1:0]));
      check("rsp_err", 32'(rsp_err), 32'(exp_q[0][DATA_W]));
    end
    check("rsp_count", 32'(rsp_count), 32'(exp_q.size()) - 32'(last_acc));
    check("fsm_state", 32'(fsm_state), run_m ? 32'(ST_RUN) : 32'(ST_LOAD));
    accepted = req_valid && exp_ready;
    @(posedge Clock);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (exp_valid && rsp_ready) void'(exp_q.pop_front());
      if (accepted) exp_q.push_back(exp_word(req_addr));
    end
    last_acc = accepted;
    if (!run_m && load_en && int'(load_addr) < DEPTH) mem_m[load_addr[8:0]] = load_data;
    if (!run_m && load_done) run_m = 1'b1;
    #1;
  endtask

  task automatic load_word(input int a, input logic [DATA_W-1:0] d, input bit done);
    load_en   = 1'b1;
    load_addr = ADDR_W'(a);
    load_data = d;
    load_done = done;
    req_valid = 1'($urandom_range(0, 1));
    req_addr  = 16'($urandom);
    cycle(acc);
    load_en   = 1'b0;
    load_done = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic req(input logic [ADDR_W-1:0] a);
    bit got;
    got       = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int i = 0; i < 20 && !got; i++) cycle(got);
    if (!got) check("req_accept_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  initial begin
    logic [ADDR_W-1:0] bp_addr [3];
    int k;
    n_tests = 0; n_fail = 0; run_m = 0; last_acc = 0;
    load_en = 0; load_addr = '0; load_data = '0; load_done = 0;
    req_valid = 0; req_addr = '0; rsp_ready = 1; flush = 0;

    // Reset state.
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(ST_LOAD));
    check("rst_count", 32'(rsp_count), 32'd0);
    @(negedge Clock);
    reset = 1'b1;
    @(posedge Clock);
    #1;

    // Program load with stray requests; out-of-range writes alias 0 and 1
    // if not dropped; the final word shares its cycle with load_done.
    load_word(0, 16'h1234, 1'b0);
    load_word(1, 16'hABCD, 1'b0);
    for (int a = 2; a < DEPTH - 1; a++) load_word(a, 16'($urandom), 1'b0);
    load_word(DEPTH, 16'hFFFF, 1'b0);
    load_word(DEPTH + 1, 16'hFFFF, 1'b0);
    load_word(DEPTH - 1, 16'($urandom), 1'b1);

    // Back-to-back fetches of the two known words.
    rsp_ready = 1'b1;
    req(16'd0);
    req(16'd1);
    req(16'd511);
    idle(2);

    // Writes in RUN must not land.
    load_en = 1'b1; load_addr = 16'd5; load_data = ~mem_m[5]; load_done = 1'b1;
    cycle(acc);
    load_en = 1'b0; load_done = 1'b0;
    req(16'd5);
    idle(2);

    // Backpressure: only two of three requests fit.
    bp_addr[0] = 16'd2; bp_addr[1] = 16'd3; bp_addr[2] = 16'd4;
    k = 0;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_addr = bp_addr[k];
      cycle(acc);
      if (acc && k < 2) k++;
      else if (acc) k = 3;
    end
    check("bp_accepted", 32'(k), 32'd2);
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && k < 3; i++) begin
      req_addr = bp_addr[k];
      cycle(acc);
      if (acc) k++;
    end
    check("bp_all_accepted", 32'(k), 32'd3);
    idle(3);

    // Range errors followed by a normal fetch.
    req(16'd512);
    req(16'd1);
    req(16'hFFFF);
    idle(3);

    // Flush with two buffered responses.
    rsp_ready = 1'b0;
    req(16'd6);
    req(16'd7);
    idle(1);
    flush = 1'b1; req_valid = 1'b1; req_addr = 16'd8;
    cycle(acc);
    flush = 1'b0; req_valid = 1'b0;
    cycle(acc);
    check("flush_valid", 32'(rsp_valid), 32'd0);
    check("flush_count", 32'(rsp_count), 32'd0);
    rsp_ready = 1'b1;
    req(16'd8);
    idle(2);

    // Random traffic including occasional flushes and ignored loads.
    for (int i = 0; i < 1500; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(512, 65535))
                                              : 16'($urandom_range(0, 511));
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      load_en   = 1'($urandom_range(0, 1));
      load_addr = 16'($urandom_range(0, 511));
      load_data = 16'($urandom);
      load_done = 1'($urandom_range(0, 1));
      cycle(acc);
    end
    flush = 1'b0; load_en = 1'b0; load_done = 1'b0; rsp_ready = 1'b1;
    idle(4);

    // Reset with one response pending.
    rsp_ready = 1'b0;
    req(16'd2);
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_state", 32'(fsm_state), 32'(ST_LOAD));
    exp_q.delete();
    run_m = 1'b0;
    last_acc = 1'b0;
    @(negedge Clock);
    #1;
    reset = 1'b1;
    @(posedge Clock);
    #1;
    req_valid = 1'b1; req_addr = 16'd0;
    cycle(acc);
    req_valid = 1'b0;
    load_done = 1'b1;
    cycle(acc);
    load_done = 1'b0;
    rsp_ready = 1'b1;
    req(16'd0);
    req(16'd1);
    idle(3);
    check("final_idle", 32'(rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 16: instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16: request address width in bits.
REQ-003 SHALL have parameter DEPTH, default 512: number of instruction words (power of two, >=2).
REQ-004 SHALL have parameter RSP_DEPTH, default 2: response buffer entries (>=1).
REQ-005 SHALL have port Clock, input, 1: the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port load_en, input, 1: write strobe for program load.
REQ-008 SHALL have port load_addr, input, ADDR_W: program load word address.
REQ-009 SHALL have port load_data, input, DATA_W: program load word.
REQ-010 SHALL have port load_done, input, 1: single-cycle pulse that ends program load.
REQ-011 SHALL have port req_valid, input, 1: fetch request valid.
REQ-012 SHALL have port req_ready, output, 1: fetch request accepted when both valid and ready are high.
REQ-013 SHALL have port req_addr, input, ADDR_W: fetch word address.
REQ-014 SHALL have port rsp_valid, output, 1: response valid.
REQ-015 SHALL have port rsp_ready, input, 1: response consumed when both valid and ready are high.
REQ-016 SHALL have port rsp_data, output, DATA_W: fetched word.
REQ-017 SHALL have port rsp_err, output, 1: the address was out of range (address >= DEPTH).
REQ-018 SHALL have port flush, input, 1: discards the in-flight read and all buffered responses.

Function
REQ-019 SHALL implement an FSM with states LOAD and RUN; reset enters LOAD.
REQ-020 In LOAD: req_ready=0; load_en with load_addr<DEPTH writes load_data to word load_addr; out-of-range load writes are dropped.
REQ-021 A load_done pulse in LOAD SHALL move the FSM to RUN on the next edge; a load_en in the same cycle SHALL still be written.
REQ-022 In RUN, load_en and load_done SHALL be ignored; the memory is read-only.
REQ-023 Memory read SHALL be synchronous with one-cycle latency; storage is an internal DEPTH x DATA_W array indexed by address[log2(DEPTH)-1:0].
REQ-024 req_ready SHALL be 1 in RUN when flush=0 and (buffer count + in-flight) < RSP_DEPTH.
REQ-025 A request accepted at edge N SHALL present rsp_valid=1 in the cycle after edge N when the buffer is empty (bypass); otherwise the response is queued behind older ones, in order.
REQ-026 An un-consumed bypass response SHALL be written into the buffer; no response is ever lost or duplicated.
REQ-027 Back-to-back requests with rsp_ready=1 held high SHALL sustain one response per cycle.
REQ-028 Out-of-range requests SHALL produce rsp_err=1 and rsp_data=0, with the same latency and ordering as in-range requests.
REQ-029 flush SHALL clear the in-flight flag and the buffer at the next edge; rsp_valid SHALL be 0 in the cycle after flush; a request is not accepted during flush.
REQ-030 Simultaneous push and pop with the buffer full SHALL be legal; the count SHALL be unchanged.
REQ-031 Buffer pointers SHALL wrap modulo RSP_DEPTH.

Reset
REQ-032 Asserted reset SHALL immediately force: state=LOAD, req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, buffer count, pointers and in-flight flag=0.
REQ-033 Memory array contents SHALL NOT be reset.
REQ-034 Reset asserted mid-operation SHALL discard all pending responses; after deassertion a new load phase is required.

Structure
REQ-035 A shared package imem_pkg SHALL hold the FSM state enumeration type and the default parameter constants.
REQ-036 The response buffer SHALL be a sub-module imem_rsp_fifo, parametrised by width (DATA_W+1) and RSP_DEPTH.

Verification
REQ-037 Load: write 0x1234@0, 0xABCD@1, then pulse load_done; request address 0 then 1 with rsp_ready=1 -> responses 0x1234 then 0xABCD on consecutive cycles, first one cycle after acceptance.
REQ-038 Backpressure: rsp_ready=0, issue 3 requests with RSP_DEPTH=2 -> 2 accepted, then req_ready=0; raise rsp_ready -> in-order data, and req_ready returns.
REQ-039 Range: request address 512 with DEPTH=512 -> rsp_err=1, rsp_data=0; a following request to address 1 -> rsp_err=0, data 0xABCD.
REQ-040 Flush: 2 responses buffered, pulse flush -> rsp_valid=0 next cycle, buffer count 0; the next request is answered normally.
REQ-041 Gating: load_en to address 5 in RUN -> word 5 unchanged; requests during LOAD -> req_ready=0.
REQ-042 Reset: assert reset while 1 response is pending -> rsp_valid and req_ready drop asynchronously; after release, state=LOAD.
